// File: rtl/mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_arbiter_pkg
// Shared types and constants for the unified-memory arbiter.
//   tag_e : owner tag carried alongside each in-flight memory read
//           TAG_NONE = no read issued (idle cycle or store)
//           TAG_I    = read belongs to the instruction-fetch port
//           TAG_D    = read belongs to the load/store port
// -----------------------------------------------------------------------------
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_I    = 2'd1,
        TAG_D    = 2'd2
    } tag_e;

    // Width of the starvation counter; STARVE_LIMIT must fit (max 15).
    localparam int STARVE_W = 4;

    // Tag to push into the return pipe for a given grant pattern.
    function automatic tag_e grant_tag(input logic i_gnt, input logic d_gnt, input logic d_we);
        tag_e t;
        t = TAG_NONE;
        if (i_gnt) begin
            t = TAG_I;
        end else if (d_gnt && !d_we) begin
            t = TAG_D;
        end
        return t;
    endfunction

endpackage

// File: rtl/mem_arbiter_tag_pipe.sv
// -----------------------------------------------------------------------------
// mem_tag_pipe
// DEPTH-deep shift register of read-owner tags. One entry enters every cycle;
// the oldest entry leaves on tag_o in the cycle the memory returns its data.
// Ports:
//   clk         in  clock, rising edge
//   rst         in  synchronous active-high clear (all entries -> TAG_NONE)
//   tag_i       in  tag of the access issued this cycle
//   tag_o       out tag of the access whose data is on memQ this cycle
//   d_pending_o out a load is issued but its data has not reached the output yet
// -----------------------------------------------------------------------------
module mem_tag_pipe
    import mem_arbiter_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic rst,
    input  tag_e tag_i,
    output tag_e tag_o,
    output logic d_pending_o
);

    tag_e pipe_q [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                pipe_q[i] <= TAG_NONE;
            end
        end else begin
            pipe_q[0] <= tag_i;
            for (int i = 1; i < DEPTH; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign tag_o = pipe_q[DEPTH-1];

    // The output stage is excluded: its data is being delivered this cycle.
    always_comb begin
        d_pending_o = 1'b0;
        for (int i = 0; i < DEPTH - 1; i++) begin
            if (pipe_q[i] == TAG_D) begin
                d_pending_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Shares one single-port synchronous memory between instruction fetch (IF)
// and load/store (MEM). The data port wins by default; after STARVE_LIMIT
// consecutive denied IF cycles the IF port is forced to win. Reads are tagged
// so each returning word is steered back to the port that asked for it.
//
// Optional feature macro: MEMARB_PERF_EN builds the conflictCnt / forceCnt
// performance counters; without it both ports are tied to 0.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   iReq/iAddr -> iGnt       IF read request, combinational grant
//   iValid/iData             returned instruction word
//   dReq/dWe/dAddr/dWdata    MEM request (store when dWe=1), dGnt grant
//   dValid/dRdata            returned load word
//   stallIF, stallMEM        pipeline freeze controls
//   memAddr/memWe/memWdata/memRen -> memory, memQ <- memory
//   conflictCnt, forceCnt    performance counters (feature-gated)
// -----------------------------------------------------------------------------
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 10,
    parameter int READ_LAT     = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              iReq,
    input  logic [31:0]       iAddr,
    output logic              iGnt,
    output logic              iValid,
    output logic [31:0]       iData,
    input  logic              dReq,
    input  logic              dWe,
    input  logic [31:0]       dAddr,
    input  logic [31:0]       dWdata,
    output logic              dGnt,
    output logic              dValid,
    output logic [31:0]       dRdata,
    output logic              stallIF,
    output logic              stallMEM,
    output logic [ADDR_W-1:0] memAddr,
    output logic              memWe,
    output logic [31:0]       memWdata,
    output logic              memRen,
    input  logic [31:0]       memQ,
    output logic [31:0]       conflictCnt,
    output logic [31:0]       forceCnt
);

    localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

    logic [STARVE_W-1:0] starve_q, starve_d;
    logic [31:0]         idata_q, drdata_q;
    logic                force_w;
    logic                d_pending;
    tag_e                push_tag, ret_tag;

    // ---------------- grant ----------------
    always_comb begin
        force_w = iReq && (starve_q == LIMIT);
        dGnt    = !rst && dReq && !force_w;
        iGnt    = !rst && iReq && !dGnt;
    end

    // ---------------- memory drive ----------------
    always_comb begin
        memAddr  = '0;
        memWdata = '0;
        if (dGnt) begin
            memAddr  = dAddr[ADDR_W+1:2];
            memWdata = dWdata;
        end else if (iGnt) begin
            memAddr  = iAddr[ADDR_W+1:2];
        end
        memWe  = dGnt && dWe;
        memRen = iGnt || (dGnt && !dWe);
    end

    // ---------------- starvation counter ----------------
    always_comb begin
        starve_d = starve_q;
        if (!iReq || iGnt) begin
            starve_d = '0;
        end else if (starve_q != LIMIT) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

    // ---------------- return path ----------------
    assign push_tag = grant_tag(iGnt, dGnt, dWe);

    mem_tag_pipe #(.DEPTH(READ_LAT)) u_tag_pipe (
        .clk         (clk),
        .rst         (rst),
        .tag_i       (push_tag),
        .tag_o       (ret_tag),
        .d_pending_o (d_pending)
    );

    // Valids are masked during reset so a read caught mid-flight never surfaces.
    always_comb begin
        iValid = !rst && (ret_tag == TAG_I);
        dValid = !rst && (ret_tag == TAG_D);
        iData  = iValid ? memQ : idata_q;
        dRdata = dValid ? memQ : drdata_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idata_q  <= '0;
            drdata_q <= '0;
        end else begin
            idata_q  <= iData;
            drdata_q <= dRdata;
        end
    end

    // ---------------- stalls ----------------
    assign stallIF  = iReq && !iGnt;
    assign stallMEM = (dReq && !dGnt) || d_pending;

    // ---------------- performance counters ----------------
`ifdef MEMARB_PERF_EN
    logic [31:0] conflict_q, force_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            conflict_q <= '0;
            force_q    <= '0;
        end else begin
            if (iReq && dReq) begin
                conflict_q <= conflict_q + 32'd1;
            end
            if (iGnt && force_w) begin
                force_q <= force_q + 32'd1;
            end
        end
    end

    assign conflictCnt = conflict_q;
    assign forceCnt    = force_q;
`else
    assign conflictCnt = '0;
    assign forceCnt    = '0;
`endif

    // Byte-lane and above-range address bits are intentionally ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{iAddr[31:ADDR_W+2], iAddr[1:0],
                                dAddr[31:ADDR_W+2], dAddr[1:0]};

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Two arbiter instances share one stimulus stream: u_dut1 (READ_LAT=1) and
// u_dut3 (READ_LAT=3), each with its own behavioural memory. Memory word i is
// preloaded with 32'h1000_0000 + i so returned data identifies its address.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // ---------------- shared stimulus ----------------
    logic        iReq, dReq, dWe;
    logic [31:0] iAddr, dAddr, dWdata;

    // ---------------- dut1 (READ_LAT=1) ----------------
    logic        iGnt1, iValid1, dGnt1, dValid1, stallIF1, stallMEM1, memWe1, memRen1;
    logic [31:0] iData1, dRdata1, memWdata1, memQ1, conflictCnt1, forceCnt1;
    logic [9:0]  memAddr1;

    // ---------------- dut3 (READ_LAT=3) ----------------
    logic        iGnt3, iValid3, dGnt3, dValid3, stallIF3, stallMEM3, memWe3, memRen3;
    logic [31:0] iData3, dRdata3, memWdata3, memQ3, conflictCnt3, forceCnt3;
    logic [9:0]  memAddr3;

    mem_arbiter #(.ADDR_W(10), .READ_LAT(1), .STARVE_LIMIT(4)) u_dut1 (
        .clk(clk), .rst(rst),
        .iReq(iReq), .iAddr(iAddr), .iGnt(iGnt1), .iValid(iValid1), .iData(iData1),
        .dReq(dReq), .dWe(dWe), .dAddr(dAddr), .dWdata(dWdata),
        .dGnt(dGnt1), .dValid(dValid1), .dRdata(dRdata1),
        .stallIF(stallIF1), .stallMEM(stallMEM1),
        .memAddr(memAddr1), .memWe(memWe1), .memWdata(memWdata1), .memRen(memRen1),
        .memQ(memQ1), .conflictCnt(conflictCnt1), .forceCnt(forceCnt1)
    );

    mem_arbiter #(.ADDR_W(10), .READ_LAT(3), .STARVE_LIMIT(4)) u_dut3 (
        .clk(clk), .rst(rst),
        .iReq(iReq), .iAddr(iAddr), .iGnt(iGnt3), .iValid(iValid3), .iData(iData3),
        .dReq(dReq), .dWe(dWe), .dAddr(dAddr), .dWdata(dWdata),
        .dGnt(dGnt3), .dValid(dValid3), .dRdata(dRdata3),
        .stallIF(stallIF3), .stallMEM(stallMEM3),
        .memAddr(memAddr3), .memWe(memWe3), .memWdata(memWdata3), .memRen(memRen3),
        .memQ(memQ3), .conflictCnt(conflictCnt3), .forceCnt(forceCnt3)
    );

    // ---------------- behavioural memories ----------------
    logic [31:0] mem1 [1024];
    logic [31:0] mem3 [1024];
    logic [31:0] r3_0, r3_1;

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem1[i] = 32'h1000_0000 + i;
            mem3[i] = 32'h1000_0000 + i;
        end
        memQ1 = '0;
        memQ3 = '0;
        r3_0  = '0;
        r3_1  = '0;
    end

    always @(posedge clk) begin
        if (memWe1) mem1[memAddr1] <= memWdata1;
        if (memRen1) memQ1 <= mem1[memAddr1];
    end

    always @(posedge clk) begin
        if (memWe3) mem3[memAddr3] <= memWdata3;
        if (memRen3) r3_0 <= mem3[memAddr3];
        r3_1  <= r3_0;
        memQ3 <= r3_1;
    end

    // ---------------- scoreboard ----------------
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Pop the next expected instruction word whenever dut1 returns one.
    task automatic sb_ifetch();
        if (iValid1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL sb_unexpected_ivalid: got %h expected none", iData1);
            end else begin
                chk("sb_idata", iData1, exp_q.pop_front());
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic ir, input logic [31:0] ia, input logic dr,
                         input logic we, input logic [31:0] da, input logic [31:0] wd);
        iReq   = ir;
        iAddr  = ia;
        dReq   = dr;
        dWe    = we;
        dAddr  = da;
        dWdata = wd;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        ireq;
        logic [31:0] iaddr;
        logic        dreq;
        logic        dwe;
        logic [31:0] daddr;
        logic [31:0] dwdata;
        logic        e_ignt;
        logic        e_dgnt;
        logic        e_memwe;
        logic        e_memren;
        logic [9:0]  e_memaddr;
        logic [31:0] e_memwdata;
        logic        e_ivalid;
        logic [31:0] e_idata;
        logic        e_dvalid;
        logic [31:0] e_drdata;
        logic        e_stallif;
    } vec_t;

    vec_t vq [$];

    initial begin
        // ir  iaddr  dr we daddr  wdata        ig dg we re addr wdata        iv idata        dv drdata       sif
        // IF-only stream, one word per cycle.
        vq.push_back('{1, 32'h00, 0, 0, 32'h00, 32'h0,         1, 0, 0, 1, 10'd0,  32'h0,         0, 32'h0,         0, 32'h0,         0});
        vq.push_back('{1, 32'h04, 0, 0, 32'h00, 32'h0,         1, 0, 0, 1, 10'd1,  32'h0,         1, 32'h1000_0000, 0, 32'h0,         0});
        vq.push_back('{1, 32'h08, 0, 0, 32'h00, 32'h0,         1, 0, 0, 1, 10'd2,  32'h0,         1, 32'h1000_0001, 0, 32'h0,         0});
        vq.push_back('{0, 32'h00, 0, 0, 32'h00, 32'h0,         0, 0, 0, 0, 10'd0,  32'h0,         1, 32'h1000_0002, 0, 32'h0,         0});
        vq.push_back('{0, 32'h00, 0, 0, 32'h00, 32'h0,         0, 0, 0, 0, 10'd0,  32'h0,         0, 32'h1000_0002, 0, 32'h0,         0});
        // Conflict: data port wins, IF retries next cycle.
        vq.push_back('{1, 32'h0C, 1, 0, 32'h40, 32'h0,         0, 1, 0, 1, 10'd16, 32'h0,         0, 32'h1000_0002, 0, 32'h0,         1});
        vq.push_back('{1, 32'h0C, 0, 0, 32'h00, 32'h0,         1, 0, 0, 1, 10'd3,  32'h0,         0, 32'h1000_0002, 1, 32'h1000_0010, 0});
        vq.push_back('{0, 32'h00, 0, 0, 32'h00, 32'h0,         0, 0, 0, 0, 10'd0,  32'h0,         1, 32'h1000_0003, 0, 32'h1000_0010, 0});
        // Store then load to the same word.
        vq.push_back('{0, 32'h00, 1, 1, 32'h80, 32'hDEADBEEF,  0, 1, 1, 0, 10'd32, 32'hDEADBEEF,  0, 32'h1000_0003, 0, 32'h1000_0010, 0});
        vq.push_back('{0, 32'h00, 1, 0, 32'h80, 32'h0,         0, 1, 0, 1, 10'd32, 32'h0,         0, 32'h1000_0003, 0, 32'h1000_0010, 0});
        vq.push_back('{0, 32'h00, 0, 0, 32'h00, 32'h0,         0, 0, 0, 0, 10'd0,  32'h0,         0, 32'h1000_0003, 1, 32'hDEADBEEF,  0});
        // Unaligned load: low two address bits ignored (0x43 -> word 16).
        vq.push_back('{0, 32'h00, 1, 0, 32'h43, 32'h0,         0, 1, 0, 1, 10'd16, 32'h0,         0, 32'h1000_0003, 0, 32'hDEADBEEF,  0});
        vq.push_back('{0, 32'h00, 0, 0, 32'h00, 32'h0,         0, 0, 0, 0, 10'd0,  32'h0,         0, 32'h1000_0003, 1, 32'h1000_0010, 0});
    end

    // ---------------- main test ----------------
    logic exp_g;

    initial begin
        drive(1, 32'h0, 1, 0, 32'h40, 32'h0);
        rst = 1'b1;

        // Reset: requests present but nothing granted or returned.
        @(posedge clk);
        @(negedge clk);
        chk("rst_ignt",    {31'b0, iGnt1},   32'd0);
        chk("rst_dgnt",    {31'b0, dGnt1},   32'd0);
        chk("rst_memren",  {31'b0, memRen1}, 32'd0);
        chk("rst_memwe",   {31'b0, memWe1},  32'd0);
        chk("rst_ivalid",  {31'b0, iValid1}, 32'd0);
        chk("rst_dvalid",  {31'b0, dValid1}, 32'd0);
        chk("rst_idata",   iData1,           32'd0);
        chk("rst_drdata",  dRdata1,          32'd0);
        chk("rst_conflict", conflictCnt1,    32'd0);
        next_cycle();
        rst = 1'b0;

        // Table-driven single-cycle vectors on dut1.
        foreach (vq[k]) begin
            drive(vq[k].ireq, vq[k].iaddr, vq[k].dreq, vq[k].dwe, vq[k].daddr, vq[k].dwdata);
            @(negedge clk);
            chk($sformatf("v%0d_ignt", k),     {31'b0, iGnt1},    {31'b0, vq[k].e_ignt});
            chk($sformatf("v%0d_dgnt", k),     {31'b0, dGnt1},    {31'b0, vq[k].e_dgnt});
            chk($sformatf("v%0d_memwe", k),    {31'b0, memWe1},   {31'b0, vq[k].e_memwe});
            chk($sformatf("v%0d_memren", k),   {31'b0, memRen1},  {31'b0, vq[k].e_memren});
            chk($sformatf("v%0d_memaddr", k),  {22'b0, memAddr1}, {22'b0, vq[k].e_memaddr});
            chk($sformatf("v%0d_memwdata", k), memWdata1,         vq[k].e_memwdata);
            chk($sformatf("v%0d_ivalid", k),   {31'b0, iValid1},  {31'b0, vq[k].e_ivalid});
            chk($sformatf("v%0d_idata", k),    iData1,            vq[k].e_idata);
            chk($sformatf("v%0d_dvalid", k),   {31'b0, dValid1},  {31'b0, vq[k].e_dvalid});
            chk($sformatf("v%0d_drdata", k),   dRdata1,           vq[k].e_drdata);
            chk($sformatf("v%0d_stallif", k),  {31'b0, stallIF1}, {31'b0, vq[k].e_stallif});
            next_cycle();
        end

        // Starvation: dReq and iReq held for 10 cycles. Four denials arm the
        // force on cycle 5; the counter refills after that grant, so cycle 10
        // is forced as well.
        exp_q.push_back(32'h1000_0004);
        exp_q.push_back(32'h1000_0004);
        for (int c = 1; c <= 10; c++) begin
            drive(1, 32'h10, 1, 0, 32'h44, 32'h0);
            @(negedge clk);
            exp_g = (c == 5) || (c == 10);
            chk($sformatf("starve_c%0d_ignt", c), {31'b0, iGnt1}, {31'b0, exp_g});
            chk($sformatf("starve_c%0d_dgnt", c), {31'b0, dGnt1}, {31'b0, !exp_g});
            sb_ifetch();
            next_cycle();
        end
        drive(0, 32'h0, 0, 0, 32'h0, 32'h0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            sb_ifetch();
            next_cycle();
        end
        chk("starve_sb_drained", exp_q.size(), 32'd0);
`ifdef MEMARB_PERF_EN
        chk("perf_conflict", conflictCnt1, 32'd11);
        chk("perf_force",    forceCnt1,    32'd2);
`else
        chk("perf_conflict_off", conflictCnt1, 32'd0);
        chk("perf_force_off",    forceCnt1,    32'd0);
`endif

        // Reset mid-read on the 3-cycle-latency instance. Two IF denials also
        // pre-load the starvation counter, which reset must clear.
        drive(1, 32'h10, 1, 0, 32'h40, 32'h0);
        @(negedge clk);
        chk("rmr_a_dgnt3", {31'b0, dGnt3}, 32'd1);
        next_cycle();
        drive(1, 32'h10, 1, 0, 32'h44, 32'h0);
        @(negedge clk);
        chk("rmr_b_dgnt3",     {31'b0, dGnt3},     32'd1);
        chk("rmr_b_stallmem3", {31'b0, stallMEM3}, 32'd1);
        chk("rmr_b_stallmem1", {31'b0, stallMEM1}, 32'd0);
        next_cycle();
        rst = 1'b1;
        @(negedge clk);
        chk("rmr_rst_ignt3",   {31'b0, iGnt3},   32'd0);
        chk("rmr_rst_dgnt3",   {31'b0, dGnt3},   32'd0);
        chk("rmr_rst_memren3", {31'b0, memRen3}, 32'd0);
        chk("rmr_rst_dvalid1", {31'b0, dValid1}, 32'd0);
        next_cycle();
        rst = 1'b0;
        drive(0, 32'h0, 0, 0, 32'h0, 32'h0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("rmr_post%0d_dvalid3", c), {31'b0, dValid3}, 32'd0);
            chk($sformatf("rmr_post%0d_ivalid3", c), {31'b0, iValid3}, 32'd0);
            next_cycle();
        end
        chk("rmr_drdata3_cleared", dRdata3, 32'd0);
`ifdef MEMARB_PERF_EN
        chk("rmr_perf_conflict_cleared", conflictCnt3, 32'd0);
`endif

        // Starvation counter restarted from 0: IF wins only on the 5th cycle.
        for (int c = 1; c <= 5; c++) begin
            drive(1, 32'h10, 1, 0, 32'h48, 32'h0);
            @(negedge clk);
            chk($sformatf("rmr_starve_c%0d_ignt3", c), {31'b0, iGnt3}, {31'b0, c == 5});
            next_cycle();
        end
        drive(0, 32'h0, 0, 0, 32'h0, 32'h0);
        @(negedge clk);
`ifdef MEMARB_PERF_EN
        chk("rmr_perf_conflict", conflictCnt3, 32'd5);
        chk("rmr_perf_force",    forceCnt3,    32'd1);
`else
        chk("rmr_perf_conflict_off", conflictCnt3, 32'd0);
        chk("rmr_perf_force_off",    forceCnt3,    32'd0);
`endif

        // ---------------- final report ----------------
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
